// File: rtl/mtm_row_packer.sv
// Row packer for the matrix-transpose unit: collects NUM_PE coefficients per row into a
// two-entry ping-pong buffer. Define MTM_PACKER_BITREV_EN for bit-reversed lane placement.
module mtm_row_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_row [0:NUM_PE-1],
    output logic [ADDR_WIDTH-1:0] m_row_idx,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] row_data [0:1][0:NUM_PE-1];
    logic [ADDR_WIDTH-1:0] row_idx  [0:1];
    logic [1:0]            row_last;
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [ADDR_WIDTH-1:0] lane_cnt;
    logic [ADDR_WIDTH-1:0] row_cnt;
    logic [ADDR_WIDTH-1:0] wr_lane;
    logic                  accept;
    logic                  take;
    logic                  complete;
    logic                  at_end;

    function automatic logic [ADDR_WIDTH-1:0] lane_map(input logic [ADDR_WIDTH-1:0] k);
`ifdef MTM_PACKER_BITREV_EN
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            r[b] = k[ADDR_WIDTH-1-b];
        end
        return r;
`else
        return k;
`endif
    endfunction

    always_comb begin
        s_ready  = !full[wr_sel];
        accept   = s_valid && s_ready;
        take     = full[rd_sel] && m_ready;
        at_end   = (lane_cnt == LAST_IDX) && (row_cnt == LAST_IDX);
        complete = accept && ((lane_cnt == LAST_IDX) || s_last);
        wr_lane  = lane_map(lane_cnt);
        // Completion and take always target different buffers, so both may land at once.
        full_nxt = full;
        if (take) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (complete) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_comb begin
        m_valid   = full[rd_sel];
        m_row_idx = row_idx[rd_sel];
        m_first   = full[rd_sel] && (row_idx[rd_sel] == '0);
        m_last    = full[rd_sel] && row_last[rd_sel];
        for (int i = 0; i < NUM_PE; i++) begin
            m_row[i] = row_data[rd_sel][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            lane_cnt <= '0;
            row_cnt  <= '0;
            row_last <= '0;
            err      <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                row_idx[b] <= '0;
                for (int i = 0; i < NUM_PE; i++) begin
                    row_data[b][i] <= '0;
                end
            end
        end else begin
            full <= full_nxt;
            if (accept) begin
                // Lane 0 of a new row wipes the buffer so an early flush reads zeros.
                for (int i = 0; i < NUM_PE; i++) begin
                    if (ADDR_WIDTH'(i) == wr_lane) begin
                        row_data[wr_sel][i] <= s_data;
                    end else if (lane_cnt == '0) begin
                        row_data[wr_sel][i] <= '0;
                    end
                end
                lane_cnt <= complete ? '0 : lane_cnt + ONE;
                if (s_last != at_end) begin
                    err <= 1'b1;
                end
            end
            if (complete) begin
                row_idx[wr_sel]  <= row_cnt;
                row_last[wr_sel] <= s_last || (row_cnt == LAST_IDX);
                wr_sel           <= ~wr_sel;
                row_cnt          <= s_last ? '0 : row_cnt + ONE;
            end
            if (take) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

endmodule

// File: doc/mtm_row_packer.md
# mtm_row_packer

Upstream feeder for the matrix-transpose unit. It accepts one coefficient per cycle over a valid/ready stream and assembles NUM_PE consecutive coefficients into a full row, `NUM_PE`-lane wide. It presents completed rows, tagged with their row index inside the NUM_PE×NUM_PE matrix, on a row-wide valid/ready interface. A two-entry ping-pong row buffer lets input continue while a finished row waits for the transpose stage.

## Interface
Parameters:
- `DATA_WIDTH`, 64, coefficient width in bits.
- `NUM_PE`, 8, lanes per row and rows per matrix; must be a power of two, ≥2.
- `ADDR_WIDTH`, `$clog2(NUM_PE)`, width of the lane and row counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  input coefficient valid.
- `s_ready`  out  1  packer can accept a coefficient.
- `s_data`  in  DATA_WIDTH  input coefficient.
- `s_last`  in  1  marks the final coefficient of a matrix.
- `m_valid`  out  1  completed row available.
- `m_ready`  in  1  downstream accepts the row.
- `m_row`  out  [DATA_WIDTH-1:0] x [0:NUM_PE-1]  completed row (unpacked array, lane 0 first).
- `m_row_idx`  out  ADDR_WIDTH  row index of `m_row` within its matrix.
- `m_first`  out  1  `m_row_idx == 0`.
- `m_last`  out  1  final row of the matrix: `m_row_idx == NUM_PE-1`, or a row flushed early by `s_last`.
- `err`  out  1  sticky framing error.

## Operation
- Handshake terms: an input is accepted when `s_valid && s_ready`; an output is taken when `m_valid && m_ready`.
- State:
  - two row buffers, each holding NUM_PE lanes, a row index and a last flag;
  - `full[1:0]`, `wr_sel`, `rd_sel`;
  - `lane_cnt` and `row_cnt`, both ADDR_WIDTH wide.
- Fill path:
  - `s_ready = !full[wr_sel]`.
  - On accept, `s_data` is written to lane `lane_cnt` of buffer `wr_sel`, and `lane_cnt` increments.
- Row completion: the row completes when an accepted coefficient has `lane_cnt == NUM_PE-1`, or has `s_last == 1`. On completion:
  - `full[wr_sel] <= 1`, and `wr_sel` toggles;
  - the buffer's row index is set to `row_cnt`;
  - `lane_cnt <= 0`;
  - `row_cnt` increments and wraps at NUM_PE. It is forced to 0 when `s_last` is set.
- Early `s_last` flush: if `s_last` arrives with `lane_cnt < NUM_PE-1`, the lanes not yet written are zero. The write logic clears the whole buffer when lane 0 of a new row is written.
- Output path:
  - `m_valid = full[rd_sel]`; `m_row`, `m_row_idx` and the last flag come from buffer `rd_sel`.
  - When the row is taken, `full[rd_sel] <= 0` and `rd_sel` toggles.
- Framing error: `err` is set, and stays set until `rst`, when either
  - `s_last` is accepted while not at (lane NUM_PE-1, row NUM_PE-1), or
  - the coefficient at (lane NUM_PE-1, row NUM_PE-1) is accepted without `s_last`.
  Data flow continues normally after an error.

## Timing
- Reset: every output and all state are cleared.
  - `s_ready` = 1 after reset; `m_valid`, `m_row`, `m_row_idx`, `m_first`, `m_last` and `err` = 0.
  - `wr_sel`, `rd_sel`, `full`, `lane_cnt` and `row_cnt` = 0.
  - A reset asserted mid-row discards all partial and buffered data.
- Latency: when the completing coefficient is accepted in cycle t, `m_valid` is high in cycle t+1.
- Throughput: with `m_ready` held at 1, the packer sustains one coefficient per cycle with no bubbles.
- Both buffers full: `s_ready` = 0 until a row is taken. `s_ready` rises in the cycle after the take (registered `full`).
- Simultaneous completion and take, on different buffers, in the same cycle: both updates apply.
- `m_row` and all row metadata are stable while `m_valid && !m_ready`.
- `s_data` is ignored whenever `s_ready` = 0.

## Configuration
- `MTM_PACKER_BITREV_EN`:
  - Defined: coefficient number k of a row is written to lane `bitrev(k)` over ADDR_WIDTH bits. This gives NTT bit-reversed lane order into the transpose stage. Zero-fill on an early flush still covers every lane not written.
  - Undefined: coefficient number k goes to lane k, in natural order.

## Test plan
Unless a line gives other values, use NUM_PE=4, DATA_WIDTH=16, macro undefined.
- Reset, then stream values 0..15 with `s_last` on value 15 and `m_ready`=1 → four rows: {0,1,2,3} idx0 `m_first`, {4,5,6,7} idx1, {8,9,10,11} idx2, {12..15} idx3 `m_last`. Each row appears one cycle after its 4th beat; `err`=0; `s_ready` never drops.
- `m_ready`=0, stream 12 values → two rows are buffered; `s_ready` falls after the 8th accept. Raise `m_ready` → row {0..3} comes out first, then {4..7}, and `s_ready` returns the cycle after the first take.
- `s_last` on the 2nd beat of row 1 (values 4,5) → row {4,5,0,0} idx1 with `m_last`=1; `err`=1. The next beat starts row 0, lane 0.
- 16 values with no `s_last` → `err`=1 after the 16th accept; the next value appears as lane 0 of row idx0.
- Macro defined, values 0..3 → `m_row` = {0,2,1,3}.
- Assert `rst` for 1 cycle after 6 accepted values → all outputs 0. A fresh stream of 0..15 reproduces the first scenario exactly.
